// File: rtl/fifo_pkt_framer_if.sv
// Handshake bundle between the packet framer, its upstream byte FIFO and the
// downstream byte stream. The master side is the framer.
interface fifo_pkt_framer_if;
  logic       fifo_empty;
  logic       fifo_wr;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (
    input  fifo_empty, fifo_wr, fifo_data, m_ready,
    output fifo_rd, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_wr, fifo_data, m_ready,
    input  fifo_rd, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_pkt_framer.sv
// Frames bytes from an upstream FIFO into packets: header byte, PKT_LEN payload
// bytes, then a modulo-256 checksum of the payload flagged with m_last.
module fifo_pkt_framer #(
  parameter int unsigned PKT_LEN  = 4,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              clock,
  input  logic              rst,
  fifo_pkt_framer_if.master bus,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, HDR, POP, CAP, SEND, CKS} state_t;

  localparam logic [7:0] LEN_B = PKT_LEN[7:0];

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cks_q, cks_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_valid_q, m_valid_d;
  logic       m_last_q, m_last_d;
  logic       busy_q, busy_d;
  logic       rd_req;

  function automatic logic [7:0] cks_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // A read issued while the FIFO is being written is dropped by the FIFO,
  // so POP only advances when the strobe lands in a write-free cycle.
  assign rd_req      = (state_q == POP) && !bus.fifo_empty;
  assign bus.fifo_rd = rd_req;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign busy        = busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cks_d     = cks_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          m_data_d  = HDR_BYTE;
          m_valid_d = 1'b1;
          cnt_d     = 8'd0;
          cks_d     = 8'd0;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = POP;
        end
      end
      POP: begin
        if (rd_req && !bus.fifo_wr) state_d = CAP;
      end
      CAP: begin
        m_data_d  = bus.fifo_data;
        m_valid_d = 1'b1;
        cks_d     = cks_add(cks_q, bus.fifo_data);
        cnt_d     = cnt_q + 8'd1;
        state_d   = SEND;
      end
      SEND: begin
        if (bus.m_ready) begin
          if (cnt_q == LEN_B) begin
            m_data_d = cks_q;
            m_last_d = 1'b1;
            state_d  = CKS;
          end else begin
            m_valid_d = 1'b0;
            state_d   = POP;
          end
        end
      end
      CKS: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      cks_q     <= 8'd0;
      m_data_q  <= 8'd0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cks_q     <= cks_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
    end
  end
endmodule

// File: doc/fifo_pkt_framer.md
FIFO_PKT_FRAMER -- requirements
Module: fifo_pkt_framer

Interface
REQ-001 SHALL have parameter PKT_LEN, default 4, payload bytes per packet; legal range 1..255.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, first byte of every packet.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low (0 = in reset).
REQ-005 SHALL have port fifo_empty  input  1  empty flag of the upstream 8-bit FIFO.
REQ-006 SHALL have port fifo_wr  input  1  write strobe of the same FIFO. Monitored because a write in the same cycle blocks the FIFO's read.
REQ-007 SHALL have port fifo_data  input  8  FIFO read data, valid one cycle after an accepted read.
REQ-008 SHALL have port fifo_rd  output  1  read strobe to the FIFO.
REQ-009 SHALL have port m_valid  output  1  output byte valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts the byte when m_valid=1 and m_ready=1.
REQ-011 SHALL have port m_data  output  8  output byte.
REQ-012 SHALL have port m_last  output  1  marks the final byte (checksum) of a packet.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, HDR, POP, CAP, SEND, CKS.
REQ-015 IDLE: when fifo_empty=0, SHALL load m_data=HDR_BYTE, set m_valid=1, clear the byte counter and checksum, and go to HDR.
REQ-016 HDR: SHALL hold m_data and m_valid until m_ready=1; on that handshake SHALL drop m_valid and go to POP.
REQ-017 POP: SHALL drive fifo_rd = (state==POP) & ~fifo_empty combinationally; it is the only unregistered output.
REQ-018 POP: if fifo_rd=1 and fifo_wr=0, the read is accepted and the FSM SHALL go to CAP.
REQ-019 POP: if fifo_rd=1 and fifo_wr=1, the FIFO ignores the read, so the FSM SHALL stay in POP and retry next cycle.
REQ-020 POP: if fifo_empty=1, the FSM SHALL wait in POP, possibly indefinitely, with no timeout.
REQ-021 CAP: SHALL register m_data<=fifo_data and m_valid<=1, add fifo_data to the checksum, increment the counter, and go to SEND.
REQ-022 SEND: SHALL hold m_data and m_valid stable until m_ready=1.
REQ-023 SEND: on the m_ready handshake, SHALL go to CKS if the counter equals PKT_LEN, else to POP.
REQ-024 CKS: SHALL present m_data=checksum, m_valid=1 and m_last=1 until m_ready=1, then go to IDLE with m_valid=0 and m_last=0.
REQ-025 Checksum SHALL be the 8-bit modulo-256 sum of payload bytes only; carry is discarded; the header byte is excluded.
REQ-026 SHALL keep at most one FIFO read outstanding; fifo_rd SHALL never be high outside POP.
REQ-027 m_valid SHALL never deassert without a handshake, and m_data SHALL not change while m_valid=1 and m_ready=0.
REQ-028 m_ready asserted while m_valid=0 SHALL have no effect.
REQ-029 Minimum packet time SHALL be 2 + 3*PKT_LEN + 1 cycles with m_ready held at 1 and the FIFO never empty.
REQ-030 Back-to-back packets SHALL re-enter HDR from IDLE on the cycle after the CKS handshake if fifo_empty=0.

Reset
REQ-031 While rst=0, SHALL hold state=IDLE, fifo_rd=0, m_valid=0, m_data=8'h00, m_last=0, busy=0, counter=0 and checksum=0, independent of clock.
REQ-032 Reset mid-packet SHALL abort the packet with no checksum emitted; after release, framing SHALL restart with a fresh header.
REQ-033 Release of rst SHALL take effect on the first rising clock edge after rst returns to 1.

Verification
REQ-034 Normal packet: FIFO holds 01,02,03,FF, PKT_LEN=4, m_ready=1 -> output A5,01,02,03,FF,05 with m_last=1 only on 05; busy low afterwards.
REQ-035 Read/write collision: fifo_wr=1 during the first POP cycle -> fifo_rd stays high a second cycle, and the byte is output exactly once, not duplicated or skipped.
REQ-036 Starvation: FIFO empties after 2 of 4 payload bytes -> FSM waits in POP with fifo_rd=0; it resumes when data arrives, and the checksum covers all 4 bytes.
REQ-037 Backpressure: m_ready=0 for 5 cycles during each of HDR, SEND and CKS -> m_valid and m_data stay stable, and fifo_rd stays 0 throughout.
REQ-038 Async reset: assert rst=0 mid-cycle while in SEND -> all outputs are 0 immediately; after release with FIFO data present, the next byte out is A5.
REQ-039 Wrap: payload FF,FF,FF,FF -> checksum FC; back-to-back second packet starts with A5 one cycle after the CKS handshake.
